// File: rtl/la_demuxi3_pipe.sv
// Registered 3-way inverting demultiplexer with valid/ready on both sides.
// A two-entry skid buffer keeps in_ready a pure register output.
module la_demuxi3_pipe #(
  parameter int    DW   = 8,
  parameter string PROP = "DEFAULT"
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] d,
  input  logic          s0,
  input  logic          s1,
  output logic          valid0,
  output logic          valid1,
  output logic          valid2,
  input  logic          ready0,
  input  logic          ready1,
  input  logic          ready2,
  output logic [DW-1:0] z0,
  output logic [DW-1:0] z1,
  output logic [DW-1:0] z2
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] m_data, m_data_nxt;
  logic [DW-1:0] s_data, s_data_nxt;
  logic [1:0]    m_idx, m_idx_nxt;
  logic [1:0]    s_idx, s_idx_nxt;
  logic [1:0]    in_idx;
  logic          in_ready_q, in_ready_nxt;
  logic          m_valid;
  logic          head_ready;
  logic          in_fire;
  logic          o_fire;

  // Same decode as the inverting mux cell: s1 dominates s0
  assign in_idx  = s1 ? 2'd2 : (s0 ? 2'd1 : 2'd0);
  assign m_valid = (state != EMPTY);
  assign in_fire = in_valid & in_ready_q;
  assign o_fire  = m_valid & head_ready;

  always_comb begin
    head_ready = 1'b0;
    case (m_idx)
      2'd0:    head_ready = ready0;
      2'd1:    head_ready = ready1;
      2'd2:    head_ready = ready2;
      default: head_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    m_data_nxt = m_data;
    m_idx_nxt  = m_idx;
    s_data_nxt = s_data;
    s_idx_nxt  = s_idx;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt  = ONE;
          m_data_nxt = d;
          m_idx_nxt  = in_idx;
        end
      end
      ONE: begin
        if (in_fire && o_fire) begin
          m_data_nxt = d;
          m_idx_nxt  = in_idx;
        end else if (in_fire) begin
          state_nxt  = FULL;
          s_data_nxt = d;
          s_idx_nxt  = in_idx;
        end else if (o_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the head can move
        if (o_fire) begin
          state_nxt  = ONE;
          m_data_nxt = s_data;
          m_idx_nxt  = s_idx;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    in_ready_nxt = (state_nxt != FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      m_data     <= '0;
      m_idx      <= 2'd0;
      s_data     <= '0;
      s_idx      <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      m_data     <= m_data_nxt;
      m_idx      <= m_idx_nxt;
      s_data     <= s_data_nxt;
      s_idx      <= s_idx_nxt;
      in_ready_q <= in_ready_nxt;
    end
  end

  assign in_ready = in_ready_q;
  assign valid0   = m_valid & (m_idx == 2'd0);
  assign valid1   = m_valid & (m_idx == 2'd1);
  assign valid2   = m_valid & (m_idx == 2'd2);
  assign z0       = valid0 ? ~m_data : '1;
  assign z1       = valid1 ? ~m_data : '1;
  assign z2       = valid2 ? ~m_data : '1;

endmodule

// File: tb/tb_la_demuxi3_pipe.sv
// Self-checking bench for la_demuxi3_pipe: a FIFO-of-two model checked every
// cycle, plus hand-computed expectations from the test plan.
module tb_la_demuxi3_pipe;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] d;
  logic          s0, s1;
  logic          valid0, valid1, valid2;
  logic          ready0, ready1, ready2;
  logic [DW-1:0] z0, z1, z2;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } word_t;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] z;
  } xfer_t;

  word_t model_q[$];
  xfer_t out_log[$];
  xfer_t exp_log[$];

  always #5 clk = ~clk;

  la_demuxi3_pipe #(.DW(DW), .PROP("DEFAULT")) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d        (d),
    .s0       (s0),
    .s1       (s1),
    .valid0   (valid0),
    .valid1   (valid1),
    .valid2   (valid2),
    .ready0   (ready0),
    .ready1   (ready1),
    .ready2   (ready2),
    .z0       (z0),
    .z1       (z1),
    .z2       (z2)
  );

  function automatic logic [1:0] chan_of(input logic [1:0] sel);
    if (sel[1]) return 2'd2;
    if (sel[0]) return 2'd1;
    return 2'd0;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the block is an in-order queue of at most two words
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_q.delete();
    end else begin
      logic [2:0] rdy;
      bit accept, leave;
      rdy    = {ready2, ready1, ready0};
      accept = in_valid && (model_q.size() < 2);
      leave  = (model_q.size() > 0) && rdy[model_q[0].ch];
      if (leave) void'(model_q.pop_front());
      if (accept) model_q.push_back({d, chan_of({s1, s0})});
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic [2:0] ev;
      logic [7:0] ez [3];
      for (int k = 0; k < 3; k++) begin
        ev[k] = (model_q.size() > 0) && (model_q[0].ch == k[1:0]);
        ez[k] = ev[k] ? ~model_q[0].data : 8'hFF;
      end
      check_output("model_in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
      check_output("model_valid0", {31'd0, valid0}, {31'd0, ev[0]});
      check_output("model_valid1", {31'd0, valid1}, {31'd0, ev[1]});
      check_output("model_valid2", {31'd0, valid2}, {31'd0, ev[2]});
      check_output("model_z0", {24'd0, z0}, {24'd0, ez[0]});
      check_output("model_z1", {24'd0, z1}, {24'd0, ez[1]});
      check_output("model_z2", {24'd0, z2}, {24'd0, ez[2]});
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (valid0 && ready0) out_log.push_back({2'd0, z0});
      if (valid1 && ready1) out_log.push_back({2'd1, z1});
      if (valid2 && ready2) out_log.push_back({2'd2, z2});
    end
  end

  task automatic apply_stimulus(input logic v, input logic [7:0] data,
                                input logic [1:0] sel, input logic [2:0] rdy);
    in_valid = v;
    d        = data;
    {s1, s0} = sel;
    {ready2, ready1, ready0} = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name);
    check_output({name, "_count"}, out_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < out_log.size())
        check_output(name, {22'd0, out_log[i]}, {22'd0, exp_log[i]});
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    d        = '0;
    {s1, s0} = 2'b00;
    {ready2, ready1, ready0} = 3'b000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_en = 1'b1;

    // Reset state
    @(negedge clk);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst_valids", {29'd0, valid2, valid1, valid0}, 32'd0);
    check_output("rst_z0", {24'd0, z0}, 32'hFF);
    check_output("rst_z2", {24'd0, z2}, 32'hFF);
    @(posedge clk); #1;

    // Single word to channel 1
    apply_stimulus(1'b1, 8'h3C, 2'b01, 3'b000);
    in_valid = 1'b0;
    {ready2, ready1, ready0} = 3'b010;
    @(negedge clk);
    check_output("single_valid1", {31'd0, valid1}, 32'd1);
    check_output("single_z1", {24'd0, z1}, 32'hC3);
    check_output("single_z0", {24'd0, z0}, 32'hFF);
    check_output("single_z2", {24'd0, z2}, 32'hFF);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("single_drop", {31'd0, valid1}, 32'd0);
    @(posedge clk); #1;

    // Decode coverage
    out_log.delete();
    exp_log.delete();
    apply_stimulus(1'b1, 8'h01, 2'b00, 3'b111);
    apply_stimulus(1'b1, 8'h02, 2'b01, 3'b111);
    apply_stimulus(1'b1, 8'h03, 2'b10, 3'b111);
    apply_stimulus(1'b1, 8'h04, 2'b11, 3'b111);
    repeat (3) apply_stimulus(1'b0, 8'h00, 2'b00, 3'b111);
    exp_log.push_back({2'd0, 8'hFE});
    exp_log.push_back({2'd1, 8'hFD});
    exp_log.push_back({2'd2, 8'hFC});
    exp_log.push_back({2'd2, 8'hFB});
    check_log("decode");

    // Backpressure into the skid register
    apply_stimulus(1'b1, 8'hA0, 2'b00, 3'b000);
    apply_stimulus(1'b1, 8'hA1, 2'b00, 3'b000);
    in_valid = 1'b0;
    @(negedge clk);
    check_output("skid_full_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("skid_head_z0", {24'd0, z0}, 32'h5F);
    ready0 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("skid_second_z0", {24'd0, z0}, 32'h5E);
    check_output("skid_in_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("skid_drained", {31'd0, valid0}, 32'd0);
    @(posedge clk); #1;

    // Head-of-line blocking
    apply_stimulus(1'b1, 8'h11, 2'b10, 3'b001);
    apply_stimulus(1'b1, 8'h22, 2'b00, 3'b001);
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_output("hol_valid0_blocked", {31'd0, valid0}, 32'd0);
      check_output("hol_z2_held", {24'd0, z2}, 32'hEE);
      @(posedge clk); #1;
    end
    ready2 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("hol_valid0_released", {31'd0, valid0}, 32'd1);
    check_output("hol_z0", {24'd0, z0}, 32'hDD);
    @(posedge clk); #1;
    apply_stimulus(1'b0, 8'h00, 2'b00, 3'b111);

    // Full throughput
    out_log.delete();
    exp_log.delete();
    for (int i = 0; i < 100; i++) begin
      logic [7:0] rd;
      logic [1:0] rs;
      rd = 8'($urandom);
      rs = 2'($urandom_range(0, 3));
      exp_log.push_back({chan_of(rs), ~rd});
      apply_stimulus(1'b1, rd, rs, 3'b111);
    end
    repeat (3) apply_stimulus(1'b0, 8'h00, 2'b00, 3'b111);
    check_log("stream");

    // Asynchronous reset while FULL
    apply_stimulus(1'b1, 8'h55, 2'b00, 3'b000);
    apply_stimulus(1'b1, 8'h66, 2'b01, 3'b000);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_output("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("arst_valids", {29'd0, valid2, valid1, valid0}, 32'd0);
    check_output("arst_z0", {24'd0, z0}, 32'hFF);
    check_output("arst_z1", {24'd0, z1}, 32'hFF);
    @(negedge clk);
    #1 reset = 1'b0;
    out_log.delete();
    exp_log.delete();
    {ready2, ready1, ready0} = 3'b111;
    repeat (4) @(posedge clk);
    #1;
    check_log("arst_discard");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
